vrf_read_sequencer: RTL and testbench
=====================================

// Module: vrf_read_sequencer
// PURPOSE
//   Downstream of the instruction launcher; consumes its op_req (vs1, vs2, queue_req, acc_cnt).
//   Expands each op_req into one VRF block read per operand queue per block, on a single shared VRF read port.
//   Tags every read with its destination queue.
//   Pulses op_access_done/op_access_vs per queue when that queue's last read is granted; these feed the scoreboard.
// PARAMETERS
//   NR_OP_QUEUE      2  operand queues; queue 0 reads vs1, queue 1 reads vs2
//   VREG_W           5  vector register index width
//   ACC_CNT_W        8  width of acc_cnt (blocks to read per queue)
//   BLOCKS_PER_VREG  8  VRF blocks per vector register; power of two
//   VRF_ADDR_W       8  VRF block address width
// PORTS
//   clk_i             in   1                      clock
//   rst_ni            in   1                      async reset, active low
//   op_req_valid_i    in   1                      op_req valid
//   op_req_ready_o    out  1                      op_req accepted when valid&&ready
//   op_req_vs1_i      in   VREG_W                 source reg for queue 0
//   op_req_vs2_i      in   VREG_W                 source reg for queue 1
//   op_req_queue_i    in   NR_OP_QUEUE            per-queue enable (queue_req)
//   op_req_acc_cnt_i  in   ACC_CNT_W              blocks per enabled queue
//   opq_ready_i       in   NR_OP_QUEUE            queue q can take one more block
//   vrf_req_valid_o   out  1                      VRF read request
//   vrf_req_addr_o    out  VRF_ADDR_W             VRF block address
//   vrf_req_queue_o   out  $clog2(NR_OP_QUEUE)    destination queue tag
//   vrf_req_gnt_i     in   1                      VRF accepted read this cycle
//   op_access_done_o  out  NR_OP_QUEUE            1-cycle pulse: queue q finished
//   op_access_vs_o    out  NR_OP_QUEUE*VREG_W     vreg read by queue q; valid with done
// BEHAVIOUR
//   Reset: state=IDLE. All outputs 0 except op_req_ready_o=1. remaining[]=0, rr_ptr=0, no pending done.
//   FSM IDLE: op_req_ready_o=1. On accept, latch per queue:
//     vs[q]; remaining[q] = queue[q] ? acc_cnt : 0; idx[q]=0; go ACTIVE.
//   ACTIVE: op_req_ready_o=0.
//     Go IDLE the cycle after all remaining[]==0 and no request is outstanding.
//     Min gap between back-to-back accepts: 1 idle-ready cycle after final grant.
//   Accept with queue_req==0: consumed; no reads; no done pulse; ACTIVE for 1 cycle.
//   Queue enabled with acc_cnt==0: no reads; done[q] pulses the cycle after accept.
//   Arbitration: when no request is outstanding, pick one eligible queue.
//     Eligible = remaining[q]!=0 && opq_ready_i[q].
//     Drive vrf_req_valid_o=1 from a register the next cycle (1-cycle arbitration latency).
//   Hold rule: while valid && !gnt, addr and queue tag stay stable regardless of opq_ready_i changes.
//   On gnt: remaining[q]--, idx[q]++. Re-arbitrate the same cycle, so reads stream one per cycle under continuous gnt.
//   Address: (vs[q]*BLOCKS_PER_VREG + idx[q]) mod 2^VRF_ADDR_W.
//     Crossing into vs+1 is intended (LMUL>1). Wrap at top of the address space is silent.
//   Done: registered; op_access_done_o[q]=1 for exactly one cycle after the grant that takes remaining[q] to 0.
//     op_access_vs_o[q]=vs[q] in that cycle, 0 otherwise.
//     Multiple queues may pulse in the same cycle (acc_cnt==0 case).
//   Reset mid-operation: all counters, pending request and pending done are dropped; no done pulse is emitted.
// CONFIGURATION
//   VRF_SEQ_RR_ARB_EN defined:
//     round-robin arbitration; rr_ptr moves to (granted queue+1) mod NR_OP_QUEUE on each gnt.
//   Not defined:
//     fixed priority, lowest eligible queue index wins; rr_ptr absent.
// TESTING
//   1) queue=01, vs1=3, acc_cnt=4, gnt=1 -> addr 24,25,26,27 on consecutive cycles;
//      done[0]=1, vs[0]=3 the cycle after the 4th grant; ready=1 the next cycle.
//   2) queue=11, vs1=1, vs2=2, acc_cnt=2 -> RR_ARB_EN: addr/tag 8/0,16/1,9/0,17/1;
//      undefined: 8,9,16,17; both done pulses occur.
//   3) gnt=0 for 3 cycles mid-stream -> valid, addr, tag held constant; remaining unchanged; resumes on gnt.
//   4) opq_ready_i=2'b01, queue=11 -> only queue-0 reads;
//      raise opq_ready_i[1] -> queue-1 reads start within 1 cycle.
//   5) queue=01, acc_cnt=0 -> no vrf_req_valid_o; done[0] pulses 1 cycle after accept, vs=vs1.
//   6) rst_ni low after 2 of 4 grants -> all outputs reset; after release ready=1, valid=0, no done pulse.

Source files
------------

// File: rtl/vrf_read_sequencer.sv
// Expands accepted op_reqs into tagged VRF block reads on one shared read port.
// Define VRF_SEQ_RR_ARB_EN for round-robin queue arbitration; otherwise lowest eligible queue wins.
module vrf_read_sequencer #(
    parameter int NR_OP_QUEUE     = 2,
    parameter int VREG_W          = 5,
    parameter int ACC_CNT_W       = 8,
    parameter int BLOCKS_PER_VREG = 8,
    parameter int VRF_ADDR_W      = 8,
    localparam int QW = (NR_OP_QUEUE > 1) ? $clog2(NR_OP_QUEUE) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          op_req_valid_i,
    output logic                          op_req_ready_o,
    input  logic [VREG_W-1:0]             op_req_vs1_i,
    input  logic [VREG_W-1:0]             op_req_vs2_i,
    input  logic [NR_OP_QUEUE-1:0]        op_req_queue_i,
    input  logic [ACC_CNT_W-1:0]          op_req_acc_cnt_i,
    input  logic [NR_OP_QUEUE-1:0]        opq_ready_i,
    output logic                          vrf_req_valid_o,
    output logic [VRF_ADDR_W-1:0]         vrf_req_addr_o,
    output logic [QW-1:0]                 vrf_req_queue_o,
    input  logic                          vrf_req_gnt_i,
    output logic [NR_OP_QUEUE-1:0]        op_access_done_o,
    output logic [NR_OP_QUEUE*VREG_W-1:0] op_access_vs_o
);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e                  state, state_next;
    logic [VREG_W-1:0]       req_vs    [NR_OP_QUEUE];
    logic [VREG_W-1:0]       vs_r      [NR_OP_QUEUE];
    logic [ACC_CNT_W-1:0]    remaining [NR_OP_QUEUE];
    logic [ACC_CNT_W-1:0]    rem_after [NR_OP_QUEUE];
    logic [ACC_CNT_W-1:0]    idx       [NR_OP_QUEUE];
    logic [ACC_CNT_W-1:0]    idx_after [NR_OP_QUEUE];
    logic [NR_OP_QUEUE-1:0]  eligible;
    logic                    req_valid;
    logic [VRF_ADDR_W-1:0]   req_addr;
    logic [QW-1:0]           req_queue;
    logic [NR_OP_QUEUE-1:0]  done;
    logic [NR_OP_QUEUE*VREG_W-1:0] done_vs;
    logic                    accept, gnt_fire, arb_en, arb_found, all_empty;
    logic [QW-1:0]           arb_sel;
    logic [VRF_ADDR_W-1:0]   arb_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (op_req_valid_i) state_next = ACTIVE;
            ACTIVE:  if (all_empty && !req_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        op_req_ready_o = (state == IDLE);
    end

    assign accept = op_req_valid_i && op_req_ready_o;

    always_comb begin
        for (int q = 0; q < NR_OP_QUEUE; q++) begin
            req_vs[q] = (q == 0) ? op_req_vs1_i : op_req_vs2_i;
        end
    end

    // Counters as they will be after this cycle's grant, so arbitration can stream back to back.
    always_comb begin
        gnt_fire  = req_valid && vrf_req_gnt_i;
        arb_en    = !req_valid || vrf_req_gnt_i;
        all_empty = 1'b1;
        eligible  = '0;
        for (int q = 0; q < NR_OP_QUEUE; q++) begin
            rem_after[q] = remaining[q];
            idx_after[q] = idx[q];
            if (gnt_fire && req_queue == QW'(q)) begin
                rem_after[q] = remaining[q] - ACC_CNT_W'(1);
                idx_after[q] = idx[q] + ACC_CNT_W'(1);
            end
            eligible[q] = (rem_after[q] != '0) && opq_ready_i[q];
            if (remaining[q] != '0) all_empty = 1'b0;
        end
    end

`ifdef VRF_SEQ_RR_ARB_EN
    logic [QW-1:0] rr_ptr, rr_next;

    always_comb begin
        rr_next = rr_ptr;
        if (gnt_fire) rr_next = (req_queue == QW'(NR_OP_QUEUE - 1)) ? '0 : req_queue + QW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_ptr <= '0;
        else         rr_ptr <= rr_next;
    end

    always_comb begin
        int            cand;
        logic [QW-1:0] cand_q;
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int i = 0; i < NR_OP_QUEUE; i++) begin
            cand = int'(rr_next) + i;
            if (cand >= NR_OP_QUEUE) cand = cand - NR_OP_QUEUE;
            cand_q = QW'(cand);
            if (!arb_found && eligible[cand_q]) begin
                arb_found = 1'b1;
                arb_sel   = cand_q;
            end
        end
    end
`else
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int q = NR_OP_QUEUE - 1; q >= 0; q--) begin
            if (eligible[q]) begin
                arb_found = 1'b1;
                arb_sel   = QW'(q);
            end
        end
    end
`endif

    // Block address deliberately runs into the next vreg and wraps silently at the top.
    assign arb_addr = VRF_ADDR_W'(vs_r[arb_sel]) * VRF_ADDR_W'(BLOCKS_PER_VREG)
                    + VRF_ADDR_W'(idx_after[arb_sel]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int q = 0; q < NR_OP_QUEUE; q++) begin
                vs_r[q]      <= '0;
                remaining[q] <= '0;
                idx[q]       <= '0;
            end
            req_valid <= 1'b0;
            req_addr  <= '0;
            req_queue <= '0;
            done      <= '0;
            done_vs   <= '0;
        end else begin
            done    <= '0;
            done_vs <= '0;
            for (int q = 0; q < NR_OP_QUEUE; q++) begin
                if (accept) begin
                    vs_r[q]      <= req_vs[q];
                    remaining[q] <= op_req_queue_i[q] ? op_req_acc_cnt_i : '0;
                    idx[q]       <= '0;
                    if (op_req_queue_i[q] && op_req_acc_cnt_i == '0) begin
                        done[q]                      <= 1'b1;
                        done_vs[q*VREG_W +: VREG_W] <= req_vs[q];
                    end
                end else begin
                    remaining[q] <= rem_after[q];
                    idx[q]       <= idx_after[q];
                    if (gnt_fire && req_queue == QW'(q) && remaining[q] == ACC_CNT_W'(1)) begin
                        done[q]                      <= 1'b1;
                        done_vs[q*VREG_W +: VREG_W] <= vs_r[q];
                    end
                end
            end
            // A pending request is frozen until granted, whatever opq_ready_i does.
            if (arb_en) begin
                req_valid <= arb_found;
                req_addr  <= arb_found ? arb_addr : '0;
                req_queue <= arb_found ? arb_sel : '0;
            end
        end
    end

    assign vrf_req_valid_o  = req_valid;
    assign vrf_req_addr_o   = req_addr;
    assign vrf_req_queue_o  = req_queue;
    assign op_access_done_o = done;
    assign op_access_vs_o   = done_vs;

endmodule

// File: tb/tb_vrf_read_sequencer.sv
// Self-checking bench for vrf_read_sequencer: directed cases plus randomized traffic
// compared every cycle against a queue-level behavioural model.
module tb_vrf_read_sequencer;

    localparam int VW  = 5;
    localparam int BPV = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid;
    logic       op_ready;
    logic [4:0] vs1, vs2;
    logic [1:0] queue;
    logic [7:0] acc;
    logic [1:0] opq_ready;
    logic       req_valid;
    logic [7:0] req_addr;
    logic       req_tag;
    logic       gnt;
    logic [1:0] done;
    logic [9:0] done_vs;

    int n_pass = 0;
    int n_total = 0;

    vrf_read_sequencer dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .op_req_valid_i   (op_valid),
        .op_req_ready_o   (op_ready),
        .op_req_vs1_i     (vs1),
        .op_req_vs2_i     (vs2),
        .op_req_queue_i   (queue),
        .op_req_acc_cnt_i (acc),
        .opq_ready_i      (opq_ready),
        .vrf_req_valid_o  (req_valid),
        .vrf_req_addr_o   (req_addr),
        .vrf_req_queue_o  (req_tag),
        .vrf_req_gnt_i    (gnt),
        .op_access_done_o (done),
        .op_access_vs_o   (done_vs)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic v, input int a, input int b, input int q,
                                 input int cnt, input int oq, input logic g);
        op_valid  = v;
        vs1       = 5'(a);
        vs2       = 5'(b);
        queue     = 2'(q);
        acc       = 8'(cnt);
        opq_ready = 2'(oq);
        gnt       = g;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        step();
        while (!op_ready && n < 300) begin
            step();
            n++;
        end
        if (!op_ready) checkOutput({name, "_idle_timeout"}, 0, 1);
    endtask

    // Queue-level reference: per-queue blocks left, next block index, and the one outstanding read.
    int       m_rem [2];
    int       m_idx [2];
    int       m_vs  [2];
    int       m_dvs [2];
    bit       m_active, m_valid;
    int       m_addr, m_tag;
    bit [1:0] m_done;
`ifdef VRF_SEQ_RR_ARB_EN
    int       m_rr;
`endif

    function automatic void model_reset();
        for (int q = 0; q < 2; q++) begin
            m_rem[q] = 0; m_idx[q] = 0; m_vs[q] = 0; m_dvs[q] = 0;
        end
        m_active = 0; m_valid = 0; m_addr = 0; m_tag = 0; m_done = 0;
`ifdef VRF_SEQ_RR_ARB_EN
        m_rr = 0;
`endif
    endfunction

    function automatic void model_step();
        bit       accept, grant, leave;
        bit [1:0] nd;
        int       order [2];
        accept = !m_active && op_valid;
        grant  = m_valid && gnt;
        leave  = m_active && m_rem[0] == 0 && m_rem[1] == 0 && !m_valid;
        nd     = 0;
        if (grant) begin
            m_rem[m_tag]--;
            m_idx[m_tag]++;
            if (m_rem[m_tag] == 0) begin
                nd[m_tag]    = 1;
                m_dvs[m_tag] = m_vs[m_tag];
            end
`ifdef VRF_SEQ_RR_ARB_EN
            m_rr = (m_tag + 1) % 2;
`endif
        end
        if (!m_valid || grant) begin
`ifdef VRF_SEQ_RR_ARB_EN
            order[0] = m_rr;
            order[1] = (m_rr + 1) % 2;
`else
            order[0] = 0;
            order[1] = 1;
`endif
            m_valid = 0;
            for (int i = 0; i < 2; i++) begin
                if (!m_valid && m_rem[order[i]] > 0 && opq_ready[order[i]]) begin
                    m_valid = 1;
                    m_tag   = order[i];
                    m_addr  = (m_vs[m_tag] * BPV + m_idx[m_tag]) % 256;
                end
            end
        end
        if (accept) begin
            m_vs[0] = int'(vs1);
            m_vs[1] = int'(vs2);
            for (int q = 0; q < 2; q++) begin
                m_rem[q] = queue[q] ? int'(acc) : 0;
                m_idx[q] = 0;
                if (queue[q] && acc == 0) begin
                    nd[q]    = 1;
                    m_dvs[q] = m_vs[q];
                end
            end
            m_active = 1;
        end else if (leave) begin
            m_active = 0;
        end
        m_done = nd;
    endfunction

    always @(negedge clk) begin
        int exp_vs;
        if (!rst_n) model_reset();
        exp_vs = (m_done[1] ? m_dvs[1] : 0) * 32 + (m_done[0] ? m_dvs[0] : 0);
        checkOutput("model_ready", int'(op_ready), int'(!m_active));
        checkOutput("model_valid", int'(req_valid), int'(m_valid));
        if (m_valid) begin
            checkOutput("model_addr", int'(req_addr), m_addr);
            checkOutput("model_tag", int'(req_tag), m_tag);
        end
        checkOutput("model_done", int'(done), int'(m_done));
        checkOutput("model_vs", int'(done_vs), exp_vs);
        if (rst_n) model_step();
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int       exp_addr [4];
        int       exp_tag  [4];
        logic [1:0] seen;

        applyStimulus(0, 0, 0, 0, 0, 3, 1);
        rst_n = 0;
        @(negedge clk);
        checkOutput("rst_ready", int'(op_ready), 1);
        checkOutput("rst_valid", int'(req_valid), 0);
        checkOutput("rst_done", int'(done), 0);
        step();
        rst_n = 1;

        // Test 1: single queue streaming at one read per cycle.
        wait_idle("t1");
        applyStimulus(1, 3, 0, 1, 4, 3, 1);
        step();
        applyStimulus(0, 3, 0, 1, 4, 3, 1);
        @(negedge clk);
        checkOutput("t1_arb_latency_valid", int'(req_valid), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t1_valid", int'(req_valid), 1);
            checkOutput("t1_addr", int'(req_addr), 24 + k);
        end
        @(negedge clk);
        checkOutput("t1_done", int'(done), 1);
        checkOutput("t1_vs", int'(done_vs[4:0]), 3);
        @(negedge clk);
        checkOutput("t1_ready", int'(op_ready), 1);

        // Test 2: both queues; order depends on arbitration build.
`ifdef VRF_SEQ_RR_ARB_EN
        exp_addr = '{8, 16, 9, 17};
        exp_tag  = '{0, 1, 0, 1};
`else
        exp_addr = '{8, 9, 16, 17};
        exp_tag  = '{0, 0, 1, 1};
`endif
        wait_idle("t2");
        applyStimulus(1, 1, 2, 3, 2, 3, 1);
        step();
        applyStimulus(0, 1, 2, 3, 2, 3, 1);
        seen = 0;
        @(negedge clk);
        seen |= done;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen |= done;
            checkOutput("t2_addr", int'(req_addr), exp_addr[k]);
            checkOutput("t2_tag", int'(req_tag), exp_tag[k]);
        end
        @(negedge clk);
        seen |= done;
        checkOutput("t2_both_done", int'(seen), 3);

        // Test 3: grant withheld for three cycles, opq_ready wiggled meanwhile.
        wait_idle("t3");
        applyStimulus(1, 5, 0, 1, 4, 3, 1);
        step();
        applyStimulus(0, 5, 0, 1, 4, 3, 1);
        step();
        step();
        step();
        applyStimulus(0, 5, 0, 1, 4, 3, 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) applyStimulus(0, 5, 0, 1, 4, 0, 0);
            if (k == 2) applyStimulus(0, 5, 0, 1, 4, 3, 0);
            @(negedge clk);
            checkOutput("t3_hold_valid", int'(req_valid), 1);
            checkOutput("t3_hold_addr", int'(req_addr), 42);
            step();
        end
        applyStimulus(0, 5, 0, 1, 4, 3, 1);
        @(negedge clk);
        checkOutput("t3_resume_addr", int'(req_addr), 42);
        @(negedge clk);
        checkOutput("t3_next_addr", int'(req_addr), 43);

        // Test 4: queue 1 blocked until its opq_ready rises.
        wait_idle("t4");
        applyStimulus(1, 0, 4, 3, 2, 1, 1);
        step();
        applyStimulus(0, 0, 4, 3, 2, 1, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_q0_addr0", int'(req_addr), 0);
        @(negedge clk);
        checkOutput("t4_q0_addr1", int'(req_addr), 1);
        @(negedge clk);
        checkOutput("t4_blocked", int'(req_valid), 0);
        step();
        step();
        applyStimulus(0, 0, 4, 3, 2, 3, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_q1_valid", int'(req_valid), 1);
        checkOutput("t4_q1_addr", int'(req_addr), 32);
        checkOutput("t4_q1_tag", int'(req_tag), 1);

        // Test 5: enabled queue with nothing to read.
        wait_idle("t5");
        applyStimulus(1, 7, 0, 1, 0, 3, 1);
        step();
        applyStimulus(0, 7, 0, 1, 0, 3, 1);
        @(negedge clk);
        checkOutput("t5_done", int'(done), 1);
        checkOutput("t5_vs", int'(done_vs[4:0]), 7);
        checkOutput("t5_valid", int'(req_valid), 0);

        // Test 6: reset after two of four grants.
        wait_idle("t6");
        applyStimulus(1, 2, 0, 1, 4, 3, 1);
        step();
        applyStimulus(0, 2, 0, 1, 4, 3, 1);
        step();
        step();
        step();
        rst_n = 0;
        @(negedge clk);
        checkOutput("t6_rst_ready", int'(op_ready), 1);
        checkOutput("t6_rst_valid", int'(req_valid), 0);
        step();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t6_post_valid", int'(req_valid), 0);
            checkOutput("t6_post_done", int'(done), 0);
            checkOutput("t6_post_ready", int'(op_ready), 1);
        end
        step();

        // Randomized traffic, occasional resets; the per-cycle model does the checking.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 0;
                step();
                step();
                rst_n = 1;
            end
            applyStimulus($urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 3,
                          $urandom_range(0, 3) != 0);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 3, 1);
        wait_idle("final");
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
